// File: rtl/imem_refill_server_pkg.sv
// Shared types for the instruction-memory refill path.
//   Inst        : instruction word returned by the ROM
//   InstAddr    : word address into the instruction ROM
//   RefillState : refill responder FSM states
//   RefillReq   : cache-side bundle of request strobe and critical word address
package imem_refill_server_pkg;

   typedef logic [15:0] InstAddr;
   typedef logic [31:0] Inst;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BURST
   } RefillState;

   typedef struct packed {
      logic    req;
      InstAddr addr;
   } RefillReq;

endpackage

// File: rtl/imem_refill_server.sv
// Memory-side responder for instruction cache line refills.
// Accepts a request, waits LATENCY cycles, then streams BURST_LEN words
// from the combinational ROM, critical word first, wrapping in the line.
// Ports:
//   i_clock, i_reset       : clock (rising edge), async active-high reset
//   i_req, i_req_addr      : refill request and critical word address
//   o_busy                 : request not accepted / refill in progress
//   o_valid, o_last        : returned word strobe and final-beat flag
//   o_data, o_addr         : returned instruction and its word address
//   o_rom_addr, i_rom_data : combinational ROM lookup
module imem_refill_server
   import imem_refill_server_pkg::*;
#(
   parameter int LATENCY   = 4,
   parameter int BURST_LEN = 4
) (
   input  logic    i_clock,
   input  logic    i_reset,
   input  logic    i_req,
   input  InstAddr i_req_addr,
   output logic    o_busy,
   output logic    o_valid,
   output logic    o_last,
   output Inst     o_data,
   output InstAddr o_addr,
   output InstAddr o_rom_addr,
   input  Inst     i_rom_data
);

   if (LATENCY < 1) begin : g_bad_latency
      $error("imem_refill_server: LATENCY must be >= 1");
   end
   if (BURST_LEN < 2 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst
      $error("imem_refill_server: BURST_LEN must be a power of two >= 2");
   end

   localparam int      LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int      BEAT_W    = $clog2(BURST_LEN);
   localparam InstAddr LINE_MASK = InstAddr'(BURST_LEN - 1);

   RefillState        state_q, state_d;
   InstAddr           addr_q, addr_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   Inst               data_q, data_d;
   InstAddr           oaddr_q, oaddr_d;
   logic              beat_last;

   assign beat_last = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      lat_cnt_d  = lat_cnt_q;
      beat_cnt_d = beat_cnt_q;
      data_d     = data_q;
      oaddr_d    = oaddr_q;
      valid_d    = 1'b0;
      last_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            // The final beat is still being presented while already in IDLE,
            // so acceptance also waits for o_valid to clear.
            if (i_req && !valid_q) begin
               addr_d     = i_req_addr;
               lat_cnt_d  = LAT_W'(LATENCY - 1);
               beat_cnt_d = '0;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt_q == '0) begin
               state_d = BURST;
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
         end
         BURST: begin
            data_d     = i_rom_data;
            oaddr_d    = addr_q;
            valid_d    = 1'b1;
            last_d     = beat_last;
            // Only the in-line offset advances, so the address wraps within the line.
            addr_d     = (addr_q & ~LINE_MASK) | ((addr_q + InstAddr'(1)) & LINE_MASK);
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            if (beat_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         lat_cnt_q  <= '0;
         beat_cnt_q <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         data_q     <= '0;
         oaddr_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         lat_cnt_q  <= lat_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         data_q     <= data_d;
         oaddr_q    <= oaddr_d;
      end
   end

   assign o_busy     = (state_q != IDLE) || valid_q;
   assign o_valid    = valid_q;
   assign o_last     = last_q;
   assign o_data     = data_q;
   assign o_addr     = oaddr_q;
   assign o_rom_addr = addr_q;

endmodule

// File: tb/tb_imem_refill_server.sv
module tb_imem_refill_server;
   import imem_refill_server_pkg::*;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   logic    req      [2];
   InstAddr req_addr [2];
   logic    busy     [2];
   logic    valid    [2];
   logic    last     [2];
   Inst     data     [2];
   InstAddr oaddr    [2];
   InstAddr rom_addr [2];
   Inst     rom_data [2];

   always #5 clk = ~clk;

   // ROM model: data = {A5A5, addr}
   assign rom_data[0] = {16'hA5A5, rom_addr[0]};
   assign rom_data[1] = {16'hA5A5, rom_addr[1]};

   imem_refill_server #(.LATENCY(4), .BURST_LEN(4)) u_dut0 (
      .i_clock(clk), .i_reset(rst), .i_req(req[0]), .i_req_addr(req_addr[0]),
      .o_busy(busy[0]), .o_valid(valid[0]), .o_last(last[0]), .o_data(data[0]),
      .o_addr(oaddr[0]), .o_rom_addr(rom_addr[0]), .i_rom_data(rom_data[0]));

   imem_refill_server #(.LATENCY(1), .BURST_LEN(8)) u_dut1 (
      .i_clock(clk), .i_reset(rst), .i_req(req[1]), .i_req_addr(req_addr[1]),
      .o_busy(busy[1]), .o_valid(valid[1]), .o_last(last[1]), .o_data(data[1]),
      .o_addr(oaddr[1]), .o_rom_addr(rom_addr[1]), .i_rom_data(rom_data[1]));

   // Reference model: one accepted request per DUT, described by its
   // acceptance edge and critical address; outputs follow from cycle offset.
   int      checks = 0;
   int      passes = 0;
   int      fails  = 0;
   int      edge_n = 0;
   logic    act      [2];
   int      n0       [2];
   InstAddr a        [2];
   logic    busy_exp [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic check_dut(input int d);
      int      c, lat, bl;
      logic    ev, el, eb;
      InstAddr ea;
      lat = (d == 1) ? 1 : 4;
      bl  = (d == 1) ? 8 : 4;
      ev = 1'b0; el = 1'b0; eb = 1'b0; ea = '0;
      if (act[d]) begin
         c  = edge_n - n0[d] + 1;
         eb = (c <= lat + bl + 1);
         ev = (c >= lat + 2) && (c <= lat + bl + 1);
         el = (c == lat + bl + 1);
         ea = InstAddr'((int'(a[d]) & ~(bl - 1)) | ((int'(a[d]) + c - lat - 2) % bl));
      end
      busy_exp[d] = eb;
      chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(eb));
      chk($sformatf("valid%0d", d), 32'(valid[d]), 32'(ev));
      chk($sformatf("last%0d", d), 32'(last[d]), 32'(el));
      if (ev) begin
         chk($sformatf("addr%0d", d), 32'(oaddr[d]), 32'(ea));
         chk($sformatf("data%0d", d), data[d], {16'hA5A5, ea});
      end
   endtask

   // One clock: model acceptance at the coming edge, then check at the negedge.
   task automatic step();
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            act[d] = 1'b0;
         end else if (req[d] && !busy_exp[d]) begin
            act[d] = 1'b1;
            n0[d]  = edge_n + 1;
            a[d]   = req_addr[d];
         end
      end
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      check_dut(0);
      check_dut(1);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic request(input int d, input InstAddr ad);
      req[d] = 1'b1;
      req_addr[d] = ad;
      step();
      req[d] = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; req_addr[d] = '0; act[d] = 1'b0; n0[d] = 0; a[d] = '0; busy_exp[d] = 1'b0;
      end
      steps(2);
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_data%0d", d), data[d], 32'h0);
         chk($sformatf("rst_addr%0d", d), 32'(oaddr[d]), 32'h0);
      end
      steps(2);

      // Basic refill and critical-word wrap
      request(0, 16'h0010);
      steps(11);
      request(0, 16'h0012);
      steps(11);

      // Request held while busy with a different address
      request(0, 16'h0010);
      req[0] = 1'b1;
      req_addr[0] = 16'h0020;
      steps(20);
      req[0] = 1'b0;
      steps(3);

      // Async reset during cycle 7 of a burst
      request(0, 16'h0010);
      steps(6);
      #1 rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("arst_valid%0d", d), 32'(valid[d]), 32'h0);
         chk($sformatf("arst_busy%0d", d), 32'(busy[d]), 32'h0);
         chk($sformatf("arst_last%0d", d), 32'(last[d]), 32'h0);
         chk($sformatf("arst_data%0d", d), data[d], 32'h0);
         chk($sformatf("arst_addr%0d", d), 32'(oaddr[d]), 32'h0);
         act[d] = 1'b0;
         busy_exp[d] = 1'b0;
      end
      steps(2);
      rst = 1'b0;
      steps(6);
      request(0, 16'h0030);
      steps(11);

      // Short latency, long burst
      request(1, 16'h0017);
      steps(12);

      // Back-to-back: second request waits for the first acceptable edge
      request(0, 16'h0040);
      req[0] = 1'b1;
      req_addr[0] = 16'h0044;
      begin
         int prev;
         prev = n0[0];
         for (int i = 0; i < 30 && n0[0] == prev; i++) step();
      end
      req[0] = 1'b0;
      steps(11);

      // Randomized traffic on both instances
      for (int i = 0; i < 400; i++) begin
         for (int d = 0; d < 2; d++) begin
            req[d] = ($urandom_range(0, 2) == 0);
            req_addr[d] = InstAddr'($urandom);
         end
         step();
      end
      req[0] = 1'b0;
      req[1] = 1'b0;
      steps(12);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
